// File: rtl/gmii_rx_pkg.sv
// Shared state type, framing/CRC constants and status bit positions for the
// GMII receive MAC and its CRC helper.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // RX_STATUS = {oversize, runt, gmii_err, crc_err}
    localparam int unsigned ST_CRC_ERR    = 0;
    localparam int unsigned ST_GMII_ERR   = 1;
    localparam int unsigned ST_RUNT       = 2;
    localparam int unsigned ST_OVERSIZE   = 3;

    // Delay line depth: one payload byte plus the four FCS bytes
    localparam int unsigned DLY_BYTES     = 5;
    localparam int unsigned LEN_W         = 11;

endpackage

// File: rtl/gmii_rx_mac_if.sv
// GMII receive byte stream in, payload stream with status and counters out.
// The master modport is the MAC; the slave modport is its environment.
interface gmii_rx_mac_if;

    logic        GMII_RX_DV;
    logic        GMII_RX_ER;
    logic [7:0]  GMII_RXD;

    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_LAST;
    logic        RX_GOOD;
    logic [3:0]  RX_STATUS;
    logic [31:0] STAT_GOOD_CNT;
    logic [31:0] STAT_BAD_CNT;

    modport master (
        input  GMII_RX_DV,
        input  GMII_RX_ER,
        input  GMII_RXD,
        output RX_DATA,
        output RX_VALID,
        output RX_LAST,
        output RX_GOOD,
        output RX_STATUS,
        output STAT_GOOD_CNT,
        output STAT_BAD_CNT
    );

    modport slave (
        output GMII_RX_DV,
        output GMII_RX_ER,
        output GMII_RXD,
        input  RX_DATA,
        input  RX_VALID,
        input  RX_LAST,
        input  RX_GOOD,
        input  RX_STATUS,
        input  STAT_GOOD_CNT,
        input  STAT_BAD_CNT
    );

endinterface

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected 0xEDB88320) advance by one byte, LSB first.
// Also used by the TX framer.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h000000, data_i};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII RX frame extractor: strips preamble/SFD/FCS, checks CRC and length.
// Optional frame counters are built when GMII_RX_STATS_EN is defined.
module gmii_rx_mac
    import gmii_rx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic          GMII_RX_CLK,
    input  logic          RST,
    gmii_rx_mac_if.master bus
);

    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT  = '1;
    localparam logic [2:0]       DLY_FULL = 3'(DLY_BYTES);
    localparam int unsigned      DLY_W    = 8 * DLY_BYTES;

    rx_state_e          state_q, state_d;
    logic [31:0]        crc_q, crc_d, crc_nxt;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               gerr_q, gerr_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [2:0]         fill_q, fill_d;

    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               good_q, good_d;
    logic [3:0]         status_q, status_d;

    logic [3:0]         eof_status;
    logic               dv, er;
    logic [7:0]         rxd;

    assign dv  = bus.GMII_RX_DV;
    assign er  = bus.GMII_RX_ER;
    assign rxd = bus.GMII_RXD;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (rxd),
        .crc_o  (crc_nxt)
    );

    always_comb begin
        eof_status              = '0;
        eof_status[ST_CRC_ERR]  = (crc_q != CRC_RESIDUE);
        eof_status[ST_GMII_ERR] = gerr_q;
        eof_status[ST_RUNT]     = (len_q < MIN_LEN);
        eof_status[ST_OVERSIZE] = (len_q > MAX_LEN);
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        len_d    = len_q;
        gerr_d   = gerr_q;
        dly_d    = dly_q;
        fill_d   = fill_q;
        data_d   = '0;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        good_d   = 1'b0;
        status_d = '0;

        unique case (state_q)
            IDLE: begin
                if (dv) begin
                    if (rxd == PREAMBLE_BYTE) begin
                        state_d = PREAMBLE;
                    end else if (rxd == SFD_BYTE) begin
                        state_d = DATA;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!dv) begin
                    state_d = IDLE;
                end else if (rxd == SFD_BYTE) begin
                    state_d = DATA;
                end else if (rxd != PREAMBLE_BYTE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (dv) begin
                    crc_d  = crc_nxt;
                    len_d  = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
                    gerr_d = gerr_q | er;
                    dly_d  = {dly_q[DLY_W-9:0], rxd};
                    // Once full, each new byte pushes the oldest one out
                    if (fill_q == DLY_FULL) begin
                        data_d  = dly_q[DLY_W-1 -: 8];
                        valid_d = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    if (fill_q == DLY_FULL) begin
                        data_d   = dly_q[DLY_W-1 -: 8];
                        valid_d  = 1'b1;
                        last_d   = 1'b1;
                        status_d = eof_status;
                        good_d   = (eof_status == '0);
                    end
                end
            end
            DROP: begin
                if (!dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = DROP;
        endcase

        // Per-frame accumulators restart on the SFD so DATA starts clean
        if (state_d == DATA && state_q != DATA) begin
            crc_d  = CRC_INIT;
            len_d  = '0;
            gerr_d = 1'b0;
            fill_d = '0;
        end
    end

    always_ff @(posedge GMII_RX_CLK or posedge RST) begin
        if (RST) begin
            state_q  <= DROP;
            crc_q    <= CRC_INIT;
            len_q    <= '0;
            gerr_q   <= 1'b0;
            dly_q    <= '0;
            fill_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            good_q   <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            len_q    <= len_d;
            gerr_q   <= gerr_d;
            dly_q    <= dly_d;
            fill_q   <= fill_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            good_q   <= good_d;
            status_q <= status_d;
        end
    end

    assign bus.RX_DATA   = data_q;
    assign bus.RX_VALID  = valid_q;
    assign bus.RX_LAST   = last_q;
    assign bus.RX_GOOD   = good_q;
    assign bus.RX_STATUS = status_q;

`ifdef GMII_RX_STATS_EN
    logic [31:0] good_cnt_q, bad_cnt_q;
    logic        inc_good, inc_bad;

    // Bad events: bad LAST beat, too-short DATA frame, broken preamble
    always_comb begin
        inc_good = valid_d & last_d & good_d;
        inc_bad  = (valid_d & last_d & ~good_d)
                 | (state_q == DATA && !dv && fill_q != DLY_FULL)
                 | (state_q == PREAMBLE && dv &&
                    rxd != PREAMBLE_BYTE && rxd != SFD_BYTE);
    end

    always_ff @(posedge GMII_RX_CLK or posedge RST) begin
        if (RST) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            if (inc_good) good_cnt_q <= good_cnt_q + 32'd1;
            if (inc_bad)  bad_cnt_q  <= bad_cnt_q + 32'd1;
        end
    end

    assign bus.STAT_GOOD_CNT = good_cnt_q;
    assign bus.STAT_BAD_CNT  = bad_cnt_q;
`else
    assign bus.STAT_GOOD_CNT = '0;
    assign bus.STAT_BAD_CNT  = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Directed + randomized bench for gmii_rx_mac; expected beats, status and
// counters come from a frame-level reference model over the sent byte queue.
module tb_gmii_rx_mac;
    import gmii_rx_pkg::*;

    localparam int unsigned MINL = 64;
    localparam int unsigned MAXL = 1518;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_good = 0;
    int unsigned exp_bad  = 0;
    int unsigned raw_bad  = 0;
    logic [7:0]  tx[$];

    gmii_rx_mac_if bus ();

    gmii_rx_mac #(
        .MIN_FRAME_LEN (MINL),
        .MAX_FRAME_LEN (MAXL)
    ) dut (
        .GMII_RX_CLK (clk),
        .RST         (rst),
        .bus         (bus)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
`ifdef GMII_RX_STATS_EN
        chk({tag, "_good_cnt"}, 64'(bus.STAT_GOOD_CNT), 64'(exp_good));
        chk({tag, "_bad_cnt"},  64'(bus.STAT_BAD_CNT),  64'(exp_bad));
`else
        chk({tag, "_good_cnt"}, 64'(bus.STAT_GOOD_CNT), 64'(0));
        chk({tag, "_bad_cnt"},  64'(bus.STAT_BAD_CNT),  64'(0));
`endif
    endtask

    // Bit-serial CRC-32 over the first m bytes of tx
    function automatic logic [31:0] crc_over(input int unsigned m);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int unsigned i = 0; i < m; i++) begin
            b = tx[i];
            for (int unsigned k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return c;
    endfunction

    // Frame-level rules: FCS is the complemented CRC of the data, little-endian
    function automatic logic [3:0] model_status(input int unsigned n, input int er_at);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [3:0]  s;
        c    = ~crc_over(n - 4);
        fcs  = {tx[n-1], tx[n-2], tx[n-3], tx[n-4]};
        s    = '0;
        s[0] = (c != fcs);
        s[1] = (er_at >= 0) && (er_at < int'(n));
        s[2] = (n < MINL);
        s[3] = (n > MAXL);
        return s;
    endfunction

    task automatic build(input int unsigned plen, input bit corrupt);
        logic [31:0] c;
        int unsigned idx;
        tx.delete();
        for (int unsigned i = 0; i < plen; i++) tx.push_back(8'($urandom));
        c = ~crc_over(plen);
        for (int unsigned k = 0; k < 4; k++) tx.push_back(c[8*k +: 8]);
        if (corrupt) begin
            idx     = tx.size() - 1 - $urandom_range(0, 3);
            tx[idx] = tx[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
    endtask

    // Called at a negedge; returns at the negedge where the end-of-frame beat shows
    task automatic send_frame(input string tag, input int unsigned npre, input int er_at);
        int unsigned n;
        int unsigned bad;
        logic [3:0]  st;
        n   = tx.size();
        bad = 0;
        for (int unsigned i = 0; i <= npre; i++) begin
            bus.GMII_RX_DV = 1'b1;
            bus.GMII_RX_ER = 1'b0;
            bus.GMII_RXD   = (i == npre) ? SFD_BYTE : PREAMBLE_BYTE;
            @(negedge clk);
            if (bus.RX_VALID !== 1'b0) bad++;
        end
        for (int unsigned j = 0; j < n; j++) begin
            bus.GMII_RXD   = tx[j];
            bus.GMII_RX_ER = (er_at == int'(j));
            @(negedge clk);
            if (j >= 5) begin
                if (bus.RX_VALID !== 1'b1 || bus.RX_LAST !== 1'b0 || bus.RX_DATA !== tx[j-5] ||
                    bus.RX_GOOD !== 1'b0 || bus.RX_STATUS !== 4'h0) bad++;
            end else if (bus.RX_VALID !== 1'b0) begin
                bad++;
            end
        end
        bus.GMII_RX_DV = 1'b0;
        bus.GMII_RX_ER = 1'b0;
        bus.GMII_RXD   = 8'h00;
        @(negedge clk);
        chk({tag, "_beats"}, 64'(bad), 64'(0));
        if (n >= 5) begin
            st = model_status(n, er_at);
            if (st == 4'h0) exp_good++; else exp_bad++;
            chk({tag, "_last"}, 64'({bus.RX_VALID, bus.RX_LAST, bus.RX_DATA}), 64'({2'b11, tx[n-5]}));
            chk({tag, "_status"}, 64'(bus.RX_STATUS), 64'(st));
            chk({tag, "_good"}, 64'(bus.RX_GOOD), 64'(st == 4'h0));
        end else begin
            exp_bad++;
            chk({tag, "_noemit"}, 64'(bus.RX_VALID), 64'(0));
        end
        chk_counters(tag);
    endtask

    task automatic raw(input logic dv, input logic [7:0] d);
        bus.GMII_RX_DV = dv;
        bus.GMII_RX_ER = 1'b0;
        bus.GMII_RXD   = d;
        @(negedge clk);
        if (bus.RX_VALID !== 1'b0) raw_bad++;
    endtask

    initial begin
        rst            = 1'b1;
        bus.GMII_RX_DV = 1'b0;
        bus.GMII_RX_ER = 1'b0;
        bus.GMII_RXD   = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({bus.RX_VALID, bus.RX_LAST, bus.RX_GOOD, bus.RX_STATUS, bus.RX_DATA}), 64'(0));
        chk_counters("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        build(60, 1'b0);   send_frame("good64", 7, -1);
        build(60, 1'b1);   send_frame("crc_err", 7, -1);
        build(60, 1'b0);   send_frame("gmii_err", 7, 30);
        build(26, 1'b0);   send_frame("runt30", 7, -1);
        build(59, 1'b0);   send_frame("runt63", 7, -1);
        build(1514, 1'b0); send_frame("max1518", 7, -1);
        build(1515, 1'b0); send_frame("over1519", 7, -1);
        build(1, 1'b0);    send_frame("len5", 7, -1);
        build(0, 1'b0);    send_frame("len4", 7, -1);
        tx.delete();
        repeat (3) tx.push_back(8'($urandom));
        send_frame("short3", 7, -1);
        build(60, 1'b0);   send_frame("no_preamble", 0, -1);

        // Broken preamble: dropped and counted bad, later SFD ignored
        raw_bad = 0;
        raw(1'b1, 8'h55); raw(1'b1, 8'h55); raw(1'b1, 8'h12); raw(1'b1, SFD_BYTE);
        repeat (12) raw(1'b1, 8'($urandom));
        raw(1'b0, 8'h00);
        exp_bad++;
        chk("pre_drop_noemit", 64'(raw_bad), 64'(0));
        chk_counters("pre_drop");

        // Junk first byte from IDLE: dropped silently
        raw(1'b1, 8'h12); raw(1'b1, 8'h55); raw(1'b1, SFD_BYTE);
        repeat (70) raw(1'b1, 8'($urandom));
        raw(1'b0, 8'h00);
        chk("idle_drop_noemit", 64'(raw_bad), 64'(0));
        chk_counters("idle_drop");

        // Reset mid-payload with DV held high
        build(60, 1'b0);
        bus.GMII_RX_DV = 1'b1;
        bus.GMII_RX_ER = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            bus.GMII_RXD = (i == 7) ? SFD_BYTE : PREAMBLE_BYTE;
            @(negedge clk);
        end
        for (int unsigned j = 0; j < 30; j++) begin
            bus.GMII_RXD = tx[j];
            @(negedge clk);
        end
        chk("pre_rst_beat", 64'({bus.RX_VALID, bus.RX_DATA}), 64'({1'b1, tx[24]}));
        bus.GMII_RXD = tx[30];
        rst      = 1'b1;
        exp_good = 0;
        exp_bad  = 0;
        #1;
        chk("rst_outputs", 64'({bus.RX_VALID, bus.RX_LAST, bus.RX_GOOD, bus.RX_STATUS, bus.RX_DATA}), 64'(0));
        chk_counters("rst_async");
        @(negedge clk);
        rst     = 1'b0;
        raw_bad = 0;
        for (int unsigned j = 31; j < tx.size(); j++) raw(1'b1, tx[j]);
        raw(1'b0, 8'h00);
        chk("rst_rest_noemit", 64'(raw_bad), 64'(0));
        chk_counters("after_rst");
        build(60, 1'b0); send_frame("post_rst", 7, -1);

        // Back-to-back good frames, one DV=0 cycle apart
        build(60, 1'b0); send_frame("b2b_a", 7, -1);
        build(60, 1'b0); send_frame("b2b_b", 7, -1);

        for (int it = 0; it < 16; it++) begin
            int unsigned kind;
            int          er;
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                tx.delete();
                repeat ($urandom_range(0, 8)) tx.push_back(8'($urandom));
            end else begin
                build($urandom_range(40, 130), ($urandom_range(0, 3) == 0));
            end
            er = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, tx.size() + 2)) : -1;
            send_frame("rand", $urandom_range(0, 7), er);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
